// File: rtl/tcdm_lrsc_filter_if.sv
// TCDM request/response bundle used on both sides of the LR/SC filter.
interface tcdm_lrsc_filter_if #(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned IdWidth      = 3
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic                    req;
  logic                    gnt;
  logic [AddrMemWidth-1:0] add;
  logic [3:0]              amo;
  logic                    wen;
  logic [DataWidth-1:0]    wdata;
  logic [BeWidth-1:0]      be;
  logic [IdWidth-1:0]      id;
  logic [DataWidth-1:0]    rdata;

  // Requester side: issues requests, receives grant and read data.
  modport master (
    output req, add, amo, wen, wdata, be, id,
    input  gnt, rdata
  );

  // Responder side: accepts requests, returns grant and read data.
  modport slave (
    input  req, add, amo, wen, wdata, be, id,
    output gnt, rdata
  );
endinterface

// File: rtl/tcdm_lrsc_filter.sv
// LR/SC filter: one reservation per core; LR becomes a load, SC becomes a
// store (success) or a load with an overridden response (failure).
module tcdm_lrsc_filter #(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumCores     = 8,
  parameter int unsigned IdWidth      = $clog2(NumCores)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tcdm_lrsc_filter_if.slave    in_bus,
  tcdm_lrsc_filter_if.master   out_bus
);

  localparam logic [3:0] AmoNone = 4'h0;
  localparam logic [3:0] AmoLr   = 4'hB;
  localparam logic [3:0] AmoSc   = 4'hC;

  typedef struct packed {
    logic                    valid;
    logic [AddrMemWidth-1:0] addr;
  } res_t;

  typedef enum logic [1:0] {
    RESP_PASS    = 2'd0,
    RESP_SC_OK   = 2'd1,
    RESP_SC_FAIL = 2'd2
  } resp_e;

  res_t  res_q [NumCores];
  res_t  res_d [NumCores];
  resp_e resp_q, resp_d;

  logic                hs;
  logic                is_lr;
  logic                is_sc;
  logic                own_match;
  logic                sc_ok;
  logic [NumCores-1:0] match;

  assign hs    = in_bus.req & out_bus.gnt;
  assign is_lr = (in_bus.amo == AmoLr);
  assign is_sc = (in_bus.amo == AmoSc);
  assign sc_ok = is_sc & own_match;

  // Address match per entry and lookup of the requester's own entry.
  always_comb begin
    match     = '0;
    own_match = 1'b0;
    for (int i = 0; i < NumCores; i++) begin
      match[i] = res_q[i].valid && (res_q[i].addr == in_bus.add);
      if (IdWidth'(i) == in_bus.id) begin
        own_match = match[i];
      end
    end
  end

  // Request feed-through with LR/SC rewritten into plain loads/stores.
  always_comb begin
    out_bus.req   = in_bus.req;
    out_bus.add   = in_bus.add;
    out_bus.be    = in_bus.be;
    out_bus.wdata = in_bus.wdata;
    out_bus.id    = in_bus.id;
    out_bus.amo   = in_bus.amo;
    out_bus.wen   = in_bus.wen;
    in_bus.gnt    = out_bus.gnt;
    if (is_lr) begin
      out_bus.amo = AmoNone;
      out_bus.wen = 1'b0;
    end else if (is_sc) begin
      out_bus.amo = AmoNone;
      out_bus.wen = sc_ok;
    end
  end

  // Reservation table and response-select next state.
  always_comb begin
    res_d  = res_q;
    resp_d = RESP_PASS;
    if (hs) begin
      if (is_lr) begin
        for (int i = 0; i < NumCores; i++) begin
          if (IdWidth'(i) == in_bus.id) begin
            res_d[i].valid = 1'b1;
            res_d[i].addr  = in_bus.add;
          end
        end
      end else if (is_sc && !sc_ok) begin
        resp_d = RESP_SC_FAIL;
        for (int i = 0; i < NumCores; i++) begin
          if (IdWidth'(i) == in_bus.id) begin
            res_d[i].valid = 1'b0;
          end
        end
      end else if (is_sc || in_bus.wen || (in_bus.amo != AmoNone)) begin
        if (is_sc) begin
          resp_d = RESP_SC_OK;
        end
        for (int i = 0; i < NumCores; i++) begin
          if (match[i]) begin
            res_d[i].valid = 1'b0;
          end
        end
      end
    end
  end

  // State registers; reset drops every reservation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q <= RESP_PASS;
      for (int i = 0; i < NumCores; i++) begin
        res_q[i].valid <= 1'b0;
        res_q[i].addr  <= res_d[i].addr;
      end
    end else begin
      resp_q <= resp_d;
      res_q  <= res_d;
    end
  end

  // Response mux: shim data, or the SC result one cycle after the handshake.
  always_comb begin
    in_bus.rdata = out_bus.rdata;
    case (resp_q)
      RESP_SC_OK:   in_bus.rdata = '0;
      RESP_SC_FAIL: in_bus.rdata = DataWidth'(1);
      default:      in_bus.rdata = out_bus.rdata;
    endcase
  end

endmodule

// File: tb/tb_tcdm_lrsc_filter.sv
// Scoreboard bench for tcdm_lrsc_filter with a small shim/SRAM model behind it.
module tb_tcdm_lrsc_filter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NC = 8;
  localparam int unsigned IW = 3;

  typedef struct {
    string       name;
    logic        gnt;
    logic        wen;
    logic [3:0]  amo;
    logic [31:0] add;
  } req_exp_t;

  typedef struct {
    string       name;
    logic        chk;
    logic [31:0] val;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic shim_gnt = 1'b1;
  logic done = 1'b0;
  logic [31:0] rdata_q = '0;
  logic [31:0] mem [256];

  req_exp_t rq[$];
  rsp_exp_t sq[$];

  int vectors = 0;
  int fails   = 0;

  tcdm_lrsc_filter_if #(.AddrMemWidth(AW), .DataWidth(DW), .IdWidth(IW)) in_bus ();
  tcdm_lrsc_filter_if #(.AddrMemWidth(AW), .DataWidth(DW), .IdWidth(IW)) out_bus ();

  tcdm_lrsc_filter #(
    .AddrMemWidth(AW), .DataWidth(DW), .NumCores(NC), .IdWidth(IW)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .in_bus (in_bus),
    .out_bus(out_bus)
  );

  always #5 clk = ~clk;

  assign out_bus.gnt   = shim_gnt;
  assign out_bus.rdata = rdata_q;

  // Shim/SRAM model: one-cycle read latency, byte-enabled stores, AMO = add.
  always @(posedge clk) begin
    logic [31:0] old;
    if (out_bus.req && out_bus.gnt) begin
      old = mem[out_bus.add[7:0]];
      rdata_q <= old;
      if (out_bus.amo != 4'h0) begin
        mem[out_bus.add[7:0]] <= old + out_bus.wdata;
      end else if (out_bus.wen) begin
        for (int b = 0; b < 4; b++) begin
          if (out_bus.be[b]) mem[out_bus.add[7:0]][8*b +: 8] <= out_bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // One request cycle per call; stall holds the shim grant low first.
  task automatic issue(input string name, input int id, input logic [3:0] amo,
                       input logic wen, input logic [31:0] add, input logic [31:0] wdata,
                       input logic [3:0] be, input logic exp_wen, input logic [3:0] exp_amo,
                       input logic chk, input logic [31:0] exp_rd, input int stall);
    in_bus.req   = 1'b1;
    in_bus.id    = IW'(id);
    in_bus.amo   = amo;
    in_bus.wen   = wen;
    in_bus.add   = add;
    in_bus.wdata = wdata;
    in_bus.be    = be;
    for (int s = 0; s < stall; s++) begin
      shim_gnt = 1'b0;
      rq.push_back('{name, 1'b0, exp_wen, exp_amo, add});
      @(posedge clk);
      #1;
    end
    shim_gnt = 1'b1;
    rq.push_back('{name, 1'b1, exp_wen, exp_amo, add});
    sq.push_back('{name, chk, exp_rd});
    @(posedge clk);
    #1;
    in_bus.req = 1'b0;
  endtask

  task automatic lr(input string n, input int id, input logic [31:0] a, input logic [31:0] rd);
    issue(n, id, 4'hB, 1'b0, a, 32'h0, 4'hF, 1'b0, 4'h0, 1'b1, rd, 0);
  endtask

  task automatic sc(input string n, input int id, input logic [31:0] a, input logic [31:0] wd,
                    input logic ok, input int stall);
    issue(n, id, 4'hC, 1'b1, a, wd, 4'hF, ok, 4'h0, 1'b1, ok ? 32'h0 : 32'h1, stall);
  endtask

  task automatic ld(input string n, input int id, input logic [31:0] a, input logic [31:0] rd);
    issue(n, id, 4'h0, 1'b0, a, 32'h0, 4'hF, 1'b0, 4'h0, 1'b1, rd, 0);
  endtask

  task automatic st(input string n, input int id, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] be);
    issue(n, id, 4'h0, 1'b1, a, wd, be, 1'b1, 4'h0, 1'b0, 32'h0, 0);
  endtask

  // Stimulus
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    in_bus.req = 1'b0; in_bus.id = '0; in_bus.amo = '0; in_bus.wen = 1'b0;
    in_bus.add = '0; in_bus.wdata = '0; in_bus.be = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    lr("lr_c2", 2, 32'h40, 32'h0);
    sc("sc_c2_ok", 2, 32'h40, 32'hDEAD, 1'b1, 0);
    ld("ld_40_dead", 0, 32'h40, 32'hDEAD);

    lr("lr_c1", 1, 32'h40, 32'hDEAD);
    st("st_c3", 3, 32'h40, 32'h3333, 4'hF);
    sc("sc_c1_fail", 1, 32'h40, 32'h1111, 1'b0, 0);
    ld("ld_40_3333", 0, 32'h40, 32'h3333);

    lr("lr_c0_80", 0, 32'h80, 32'h0);
    lr("lr_c1_80", 1, 32'h80, 32'h0);
    issue("amoadd_c5", 5, 4'h2, 1'b0, 32'h80, 32'h5, 4'hF, 1'b0, 4'h2, 1'b1, 32'h0, 0);
    sc("sc_c0_80_fail", 0, 32'h80, 32'h9, 1'b0, 0);
    sc("sc_c1_80_fail", 1, 32'h80, 32'h9, 1'b0, 0);
    ld("ld_80_5", 0, 32'h80, 32'h5);

    lr("lr_c0_10", 0, 32'h10, 32'h0);
    lr("lr_c0_20", 0, 32'h20, 32'h0);
    sc("sc_c0_10_fail", 0, 32'h10, 32'h7, 1'b0, 0);
    sc("sc_c0_20_fail", 0, 32'h20, 32'h7, 1'b0, 0);

    lr("lr_c7_50", 7, 32'h50, 32'h0);
    st("st_c2_50_be1", 2, 32'h50, 32'h0000_00AB, 4'b0001);
    sc("sc_c7_50_fail", 7, 32'h50, 32'hFFFF, 1'b0, 0);
    ld("ld_50_ab", 0, 32'h50, 32'hAB);

    lr("lr_c3_60", 3, 32'h60, 32'h0);
    ld("ld_c5_60", 5, 32'h60, 32'h0);
    sc("sc_c3_60_ok", 3, 32'h60, 32'h77, 1'b1, 0);
    ld("ld_60_77", 0, 32'h60, 32'h77);

    lr("lr_c6_30", 6, 32'h30, 32'h0);
    sc("sc_c6_30_stall_ok", 6, 32'h30, 32'h66, 1'b1, 1);
    ld("ld_30_66", 0, 32'h30, 32'h66);
    sc("sc_c6_30_again_fail", 6, 32'h30, 32'h99, 1'b0, 0);

    lr("lr_c4_08", 4, 32'h8, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sc("sc_c4_08_post_rst_fail", 4, 32'h8, 32'h44, 1'b0, 0);
    ld("ld_08_0", 0, 32'h8, 32'h0);

    repeat (3) @(posedge clk);
    done = 1'b1;
  end

  // Monitor: checks request-side rewriting and the delayed response.
  initial begin
    logic     pending;
    int       cycles;
    req_exp_t re;
    rsp_exp_t se;
    pending = 1'b0;
    cycles  = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (pending) begin
        if (sq.size() == 0) begin
          vectors++; fails++;
          $display("FAIL resp_underflow: response with no expectation queued");
        end else begin
          se = sq.pop_front();
          if (se.chk) begin
            vectors++;
            if (in_bus.rdata !== se.val) begin
              fails++;
              $display("FAIL %s rdata: got %h expected %h", se.name, in_bus.rdata, se.val);
            end
          end
        end
      end
      if (rst) begin
        vectors++;
        if (in_bus.rdata !== rdata_q || in_bus.rdata !== 32'h0) begin
          fails++;
          $display("FAIL reset_rdata: got %h expected %h", in_bus.rdata, 32'h0);
        end
      end
      if (in_bus.req) begin
        vectors++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL req_underflow: request with no expectation queued");
        end else begin
          re = rq.pop_front();
          if ({in_bus.gnt, out_bus.req, out_bus.wen, out_bus.amo, out_bus.add} !==
              {re.gnt, 1'b1, re.wen, re.amo, re.add}) begin
            fails++;
            $display("FAIL %s req: got gnt=%b wen=%b amo=%h add=%h expected gnt=%b wen=%b amo=%h add=%h",
                     re.name, in_bus.gnt, out_bus.wen, out_bus.amo, out_bus.add,
                     re.gnt, re.wen, re.amo, re.add);
          end
        end
      end
      pending = in_bus.req && in_bus.gnt && !rst;
      if (done) break;
      if (cycles > 5000) begin
        vectors++; fails++;
        $display("FAIL timeout: stimulus did not finish within 5000 cycles");
        break;
      end
    end
    vectors++;
    if (rq.size() != 0 || sq.size() != 0) begin
      fails++;
      $display("FAIL leftover: got %0d req / %0d rsp pending expected 0", rq.size(), sq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
